axi_llc_ax_burst_master: RTL and testbench
==========================================

Name: axi_llc_ax_burst_master

Overview:
Next-generation AX master for the LLC eviction or refill path. It accepts cache descriptors and forwards them through a small descriptor FIFO. When a descriptor carries the unit's flag, it issues the line transfer on the AW or AR master channel. A line longer than the interconnect's maximum burst is split into several back-to-back INCR bursts. Sits between the tag-lookup stage and the W/R data units.

Parameters:
UnitMode, 0, 0 = eviction (uses desc.evict, evict address, AW), 1 = refill (uses desc.refill, refill address, AR)
TagLength, 22, tag bits of address
IndexLength, 4, set index bits
OffsetLength, 6, block+byte offset bits; AddrWidth = TagLength+IndexLength+OffsetLength
NoBlocks, 8, beats per cache line (>=1)
BlockSize, 64, bits per beat (power of two, >=8)
MaxBeats, 4, maximum beats per emitted burst (1..256); need not divide NoBlocks
DescDepth, 2, descriptor FIFO depth (>=1)
IdWidth, 4, master ID width
AxReqId, 0, ID placed on every burst
desc_t, logic, descriptor type (evict, refill, evict_tag, a_x_addr, a_x_lock, a_x_cache, a_x_prot)
ax_chan_t, logic, AW/AR channel struct

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
desc_i  in  desc_t  incoming descriptor
desc_valid_i  in  1  descriptor valid
desc_ready_o  out  1  descriptor accepted when valid&ready
desc_o  out  desc_t  FIFO head descriptor
desc_valid_o  out  1  FIFO not empty
desc_ready_i  in  1  downstream accepts head
ax_chan_mst_o  out  ax_chan_t  AX burst
ax_chan_valid_o  out  1  burst valid
ax_chan_ready_i  in  1  burst accepted
busy_o  out  1  burst engine not IDLE
bursts_left_o  out  8  bursts still to issue for the current line

Behaviour:
- Reset (async, rst_i=1): FIFO emptied, engine IDLE, all counters 0. Outputs: desc_valid_o=0, ax_chan_valid_o=0, ax_chan_mst_o='0, desc_o='0, busy_o=0, bursts_left_o=0. Reset mid-burst drops the in-flight line and any queued descriptors.
- flag = UnitMode ? desc_i.refill : desc_i.evict.
- Line base address:
  - Evict: {evict_tag, a_x_addr[OffsetLength+:IndexLength], OffsetLength'0}.
  - Refill: {a_x_addr[OffsetLength+:TagLength+IndexLength], OffsetLength'0}.
- desc_ready_o = ~fifo_full & (engine IDLE). It is combinational from registered state only; there is no pass-through of desc_ready_i.
- On accept: the descriptor is pushed into the FIFO. If flag=1, the engine loads the line the same edge and enters SEND.
- Descriptor output is independent of burst completion. The FIFO is first-word-fall-through with zero-latency head. Push and pop in the same cycle are legal when not empty.
- Engine FSM:
  - IDLE -> SEND on flagged accept.
  - SEND: ax_chan_valid_o=1, payload registered and held stable until handshake.
  - On handshake with beats remaining > 0: the next burst is loaded the same edge and valid stays high (no bubble).
  - On handshake of the last burst: -> IDLE, and a new descriptor can be accepted the next cycle.
- Burst k fields:
  - addr = base + k*MaxBeats*(BlockSize/8), modulo 2^AddrWidth.
  - len = min(MaxBeats, remaining)-1.
  - size = log2(BlockSize/8).
  - burst = INCR, id = AxReqId.
  - lock/cache/prot taken from the descriptor captured at accept.
- Remaining-beat counter: starts at NoBlocks and decrements by the beats of each accepted burst. bursts_left_o = ceil(remaining/MaxBeats) and saturates at 255.
- Unflagged descriptor: only pushed into the FIFO; no AX is issued and the engine stays IDLE.
- Latency: a flagged descriptor accepted at edge N gives ax_chan_valid_o=1 at N+1.
- Full FIFO: desc_ready_o=0 even if desc_ready_i=1 in that cycle.
- ax_chan_valid_o never deasserts without a handshake (AXI stability rule).

Test Plan:
- Evict, tag=0x5, index=0x3, defaults, ready tied 1 -> two bursts in consecutive cycles: addr 0x14C0 len=3 size=3, then 0x14E0 len=3; busy_o falls after the second; desc_o = input descriptor.
- Refill, NoBlocks=6, MaxBeats=4, a_x_addr=0x12345 -> bursts addr 0x12340 len=3, then 0x12360 len=1; bursts_left_o goes 2,1,0.
- Unflagged descriptor with desc_ready_i=0, DescDepth=2 -> two accepted, third sees desc_ready_o=0, ax_chan_valid_o stays 0 throughout.
- ax_chan_ready_i held 0 for 5 cycles mid-line -> payload and valid stable, desc_ready_o=0; after release the remaining burst follows with no bubble.
- rst_i pulsed during the second burst -> all outputs 0 within the reset cycle; next flagged descriptor restarts at burst 0.
- MaxBeats=8=NoBlocks -> single burst len=7; accept-to-valid latency of exactly 1 cycle.

Source files
------------

// File: rtl/axi_llc_ax_burst_master.sv
// LLC AX burst master: queues cache descriptors in a FWFT FIFO and, for flagged
// descriptors, issues the cache line as back-to-back INCR bursts on AW (evict) or AR (refill).
package axi_llc_ax_burst_master_pkg;
  typedef struct packed {
    logic        evict;
    logic        refill;
    logic [21:0] evict_tag;
    logic [31:0] a_x_addr;
    logic        a_x_lock;
    logic [3:0]  a_x_cache;
    logic [2:0]  a_x_prot;
  } desc_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
  } ax_chan_t;
endpackage

module axi_llc_ax_burst_master #(
  parameter int unsigned UnitMode     = 0,
  parameter int unsigned TagLength    = 22,
  parameter int unsigned IndexLength  = 4,
  parameter int unsigned OffsetLength = 6,
  parameter int unsigned NoBlocks     = 8,
  parameter int unsigned BlockSize    = 64,
  parameter int unsigned MaxBeats     = 4,
  parameter int unsigned DescDepth    = 2,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned AxReqId      = 0,
  parameter type desc_t    = axi_llc_ax_burst_master_pkg::desc_t,
  parameter type ax_chan_t = axi_llc_ax_burst_master_pkg::ax_chan_t
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  desc_t      desc_i,
  input  logic       desc_valid_i,
  output logic       desc_ready_o,
  output desc_t      desc_o,
  output logic       desc_valid_o,
  input  logic       desc_ready_i,
  output ax_chan_t   ax_chan_mst_o,
  output logic       ax_chan_valid_o,
  input  logic       ax_chan_ready_i,
  output logic       busy_o,
  output logic [7:0] bursts_left_o
);
  localparam int unsigned AddrWidth = TagLength + IndexLength + OffsetLength;
  localparam int unsigned PtrW      = (DescDepth > 1) ? $clog2(DescDepth) : 1;
  localparam int unsigned CntW      = $clog2(DescDepth + 1);
  localparam int unsigned RemW      = $clog2(NoBlocks + 1);
  localparam logic [AddrWidth-1:0] Stride = AddrWidth'(MaxBeats * (BlockSize / 8));

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q;
  ax_chan_t        ax_q;
  logic            valid_q;
  logic [RemW-1:0] rem_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  desc_t           mem_q [DescDepth];

  logic                 flag, push, pop, empty, full;
  logic [AddrWidth-1:0] base;
  int unsigned          rem_nx;
  logic                 unused_desc_bits;

  assign unused_desc_bits = ^{desc_i};

  function automatic logic [7:0] burst_len(input int unsigned r);
    return 8'(((r > MaxBeats) ? MaxBeats : r) - 1);
  endfunction

  assign flag  = (UnitMode != 0) ? desc_i.refill : desc_i.evict;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(DescDepth));

  // Intake is blocked while a line is in flight so the captured attributes stay coherent.
  assign desc_ready_o = ~full & (state_q == IDLE);
  assign push         = desc_valid_i & desc_ready_o;
  assign pop          = desc_ready_i & ~empty;
  assign desc_valid_o = ~empty;
  assign desc_o       = empty ? desc_t'('0) : mem_q[rd_ptr_q];

  always_comb begin
    if (UnitMode != 0)
      base = {desc_i.a_x_addr[OffsetLength+:TagLength+IndexLength], {OffsetLength{1'b0}}};
    else
      base = {desc_i.evict_tag, desc_i.a_x_addr[OffsetLength+:IndexLength], {OffsetLength{1'b0}}};
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= desc_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DescDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DescDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rem_nx = 32'(rem_q) - (32'(ax_q.len) + 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ax_q    <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (push && flag) begin
          state_q    <= SEND;
          valid_q    <= 1'b1;
          rem_q      <= RemW'(NoBlocks);
          ax_q       <= '0;
          ax_q.id    <= IdWidth'(AxReqId);
          ax_q.addr  <= base;
          ax_q.len   <= burst_len(NoBlocks);
          ax_q.size  <= 3'($clog2(BlockSize / 8));
          ax_q.burst <= 2'b01;
          ax_q.lock  <= desc_i.a_x_lock;
          ax_q.cache <= desc_i.a_x_cache;
          ax_q.prot  <= desc_i.a_x_prot;
        end
        SEND: if (ax_chan_ready_i) begin
          // Next burst is loaded on the handshake edge so valid never drops mid-line.
          if (rem_nx != 0) begin
            rem_q     <= RemW'(rem_nx);
            ax_q.addr <= ax_q.addr + Stride;
            ax_q.len  <= burst_len(rem_nx);
          end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rem_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    int unsigned bl;
    bl = (32'(rem_q) + MaxBeats - 1) / MaxBeats;
    bursts_left_o = (bl > 255) ? 8'd255 : 8'(bl);
  end

  assign ax_chan_mst_o   = ax_q;
  assign ax_chan_valid_o = valid_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_axi_llc_ax_burst_master.sv
// Scoreboard bench: three instances (evict default, refill 6-beat line, evict single 8-beat burst).
module tb_axi_llc_ax_burst_master;
  import axi_llc_ax_burst_master_pkg::*;

  typedef struct packed { ax_chan_t ax; logic [7:0] bl; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  desc_t      d_in;
  logic [2:0] dv, drdy_o, dvo, drdy_i, axv, axr, busy;
  desc_t      dout [3];
  ax_chan_t   ax   [3];
  logic [7:0] bl   [3];
  exp_t       eq   [3][$];
  int         checks = 0, errors = 0;

  axi_llc_ax_burst_master #(.UnitMode(0), .NoBlocks(8), .MaxBeats(4)) u_ev (
    .clk_i(clk), .rst_i(rst), .desc_i(d_in), .desc_valid_i(dv[0]), .desc_ready_o(drdy_o[0]),
    .desc_o(dout[0]), .desc_valid_o(dvo[0]), .desc_ready_i(drdy_i[0]), .ax_chan_mst_o(ax[0]),
    .ax_chan_valid_o(axv[0]), .ax_chan_ready_i(axr[0]), .busy_o(busy[0]), .bursts_left_o(bl[0]));

  axi_llc_ax_burst_master #(.UnitMode(1), .NoBlocks(6), .MaxBeats(4)) u_rf (
    .clk_i(clk), .rst_i(rst), .desc_i(d_in), .desc_valid_i(dv[1]), .desc_ready_o(drdy_o[1]),
    .desc_o(dout[1]), .desc_valid_o(dvo[1]), .desc_ready_i(drdy_i[1]), .ax_chan_mst_o(ax[1]),
    .ax_chan_valid_o(axv[1]), .ax_chan_ready_i(axr[1]), .busy_o(busy[1]), .bursts_left_o(bl[1]));

  axi_llc_ax_burst_master #(.UnitMode(0), .NoBlocks(8), .MaxBeats(8)) u_mb8 (
    .clk_i(clk), .rst_i(rst), .desc_i(d_in), .desc_valid_i(dv[2]), .desc_ready_o(drdy_o[2]),
    .desc_o(dout[2]), .desc_valid_o(dvo[2]), .desc_ready_i(drdy_i[2]), .ax_chan_mst_o(ax[2]),
    .ax_chan_valid_o(axv[2]), .ax_chan_ready_i(axr[2]), .busy_o(busy[2]), .bursts_left_o(bl[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input int um, input int nb, input int mb, input desc_t d);
    logic [31:0] base;
    int rem;
    exp_t e;
    base = um != 0 ? {d.a_x_addr[31:6], 6'b0} : {d.evict_tag, d.a_x_addr[9:6], 6'b0};
    rem = nb;
    for (int k = 0; rem > 0; k++) begin
      e          = '0;
      e.ax.addr  = base + 32'(k * mb * 8);
      e.ax.len   = 8'(((rem < mb) ? rem : mb) - 1);
      e.ax.size  = 3'd3;
      e.ax.burst = 2'b01;
      e.ax.lock  = d.a_x_lock;
      e.ax.cache = d.a_x_cache;
      e.ax.prot  = d.a_x_prot;
      e.bl       = 8'((rem + mb - 1) / mb);
      eq[i].push_back(e);
      rem -= mb;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input int i, input desc_t d);
    int n = 0;
    d_in = d;
    dv[i] = 1'b1;
    while (!drdy_o[i] && n < 50) begin @(posedge clk); #1; n++; end
    if (!drdy_o[i]) chk("accept_timeout", 64'(drdy_o[i]), 64'd1);
    @(posedge clk); #1;
    dv[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while ((busy[i] || eq[i].size() != 0) && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain_busy", 64'(busy[i]), 64'd0);
    chk("drain_queue", 64'(eq[i].size()), 64'd0);
    chk("bursts_left_end", 64'(bl[i]), 64'd0);
  endtask

  function automatic desc_t mk(input logic ev, input logic rf, input logic [21:0] tag,
                               input logic [31:0] addr, input logic [7:0] attr);
    desc_t d;
    d = '0;
    d.evict = ev; d.refill = rf; d.evict_tag = tag; d.a_x_addr = addr;
    d.a_x_lock = attr[7]; d.a_x_cache = attr[6:3]; d.a_x_prot = attr[2:0];
    return d;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (axv[i] && axr[i]) begin
          if (eq[i].size() == 0) chk("unexpected_ax", 64'd1, 64'd0);
          else begin
            e = eq[i].pop_front();
            chk("ax_payload", 64'(ax[i]), 64'(e.ax));
            chk("bursts_left", 64'(bl[i]), 64'(e.bl));
          end
        end
      end
    end
  end

  initial begin
    desc_t d1, d2, d3;
    dv = '0; axr = '0; drdy_i = '0; d_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_desc_valid", 64'(dvo[0]), 64'd0);
    chk("rst_ax_valid", 64'(axv[0]), 64'd0);
    chk("rst_ax", 64'(ax[0]), 64'd0);
    chk("rst_desc_o", 64'(dout[0]), 64'd0);
    chk("rst_busy", 64'(busy[0]), 64'd0);
    chk("rst_bl", 64'(bl[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; drdy_i = 3'b111; axr = 3'b111;

    // evict two-burst line, ready tied high
    d1 = mk(1'b1, 1'b0, 22'h5, 32'h0000_00D5, 8'hD5);
    push_exp(0, 0, 8, 4, d1);
    send(0, d1);
    chk("ev_latency_valid", 64'(axv[0]), 64'd1);
    chk("ev_desc_valid", 64'(dvo[0]), 64'd1);
    chk("ev_desc_o", 64'(dout[0]), 64'(d1));
    @(posedge clk); #1;
    chk("ev_no_bubble", 64'(axv[0]), 64'd1);
    chk("ev_busy_mid", 64'(busy[0]), 64'd1);
    @(posedge clk); #1;
    chk("ev_busy_fall", 64'(busy[0]), 64'd0);
    chk("ev_valid_fall", 64'(axv[0]), 64'd0);
    wait_done(0);

    // refill, 6-beat line -> 4 + 2
    push_exp(1, 1, 6, 4, mk(1'b0, 1'b1, 22'h0, 32'h0001_2345, 8'h2A));
    send(1, mk(1'b0, 1'b1, 22'h0, 32'h0001_2345, 8'h2A));
    wait_done(1);

    // unflagged descriptors fill the FIFO, no AX issued
    drdy_i[0] = 1'b0;
    d1 = mk(1'b0, 1'b1, 22'h11, 32'h100, 8'h01);
    d2 = mk(1'b0, 1'b0, 22'h22, 32'h200, 8'h02);
    d3 = mk(1'b0, 1'b0, 22'h33, 32'h300, 8'h03);
    send(0, d1);
    send(0, d2);
    d_in = d3; dv[0] = 1'b1;
    chk("full_ready", 64'(drdy_o[0]), 64'd0);
    chk("full_head", 64'(dout[0]), 64'(d1));
    chk("unflag_no_ax", 64'(axv[0]), 64'd0);
    @(posedge clk); #1;
    chk("full_ready_hold", 64'(drdy_o[0]), 64'd0);
    dv[0] = 1'b0; drdy_i[0] = 1'b1;
    @(posedge clk); #1;
    chk("fifo_second", 64'(dout[0]), 64'(d2));
    chk("fifo_second_valid", 64'(dvo[0]), 64'd1);
    @(posedge clk); #1;
    chk("fifo_empty", 64'(dvo[0]), 64'd0);
    chk("unflag_idle", 64'(busy[0]), 64'd0);

    // backpressure on the second burst for 5 cycles
    d1 = mk(1'b1, 1'b0, 22'h3A5C1, 32'hFFFF_FFC0, 8'hFF);
    push_exp(0, 0, 8, 4, d1);
    send(0, d1);
    @(posedge clk); #1;
    axr[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 64'(axv[0]), 64'd1);
      chk("stall_addr", 64'(ax[0].addr), 64'({22'h3A5C1, 4'hF, 6'h0} + 32'h20));
      chk("stall_ready", 64'(drdy_o[0]), 64'd0);
      @(posedge clk); #1;
    end
    axr[0] = 1'b1;
    wait_done(0);

    // reset during the second burst
    d1 = mk(1'b1, 1'b0, 22'h7, 32'h40, 8'h10);
    push_exp(0, 0, 8, 4, d1);
    send(0, d1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(axv[0]), 64'd0);
    chk("mid_rst_ax", 64'(ax[0]), 64'd0);
    chk("mid_rst_busy", 64'(busy[0]), 64'd0);
    chk("mid_rst_bl", 64'(bl[0]), 64'd0);
    chk("mid_rst_desc_valid", 64'(dvo[0]), 64'd0);
    chk("mid_rst_desc_o", 64'(dout[0]), 64'd0);
    eq[0].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d2 = mk(1'b1, 1'b0, 22'h9, 32'h80, 8'h33);
    push_exp(0, 0, 8, 4, d2);
    send(0, d2);
    wait_done(0);

    // MaxBeats = NoBlocks: one 8-beat burst, one-cycle latency
    d1 = mk(1'b1, 1'b0, 22'h1, 32'h1C0, 8'h44);
    push_exp(2, 0, 8, 8, d1);
    d_in = d1; dv[2] = 1'b1;
    chk("mb8_pre_valid", 64'(axv[2]), 64'd0);
    send(2, d1);
    chk("mb8_latency", 64'(axv[2]), 64'd1);
    chk("mb8_len", 64'(ax[2].len), 64'd7);
    wait_done(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
